multi_channel_blinker: RTL

MULTI_CHANNEL_BLINKER -- requirements
Module: multi_channel_blinker

---
 rtl/blinker_pkg.sv | 16 +
 rtl/blink_channel.sv | 65 ++++++
 rtl/multi_channel_blinker.sv | 93 +++++++++
 3 files changed

// File: rtl/blinker_pkg.sv
// rtl/blinker_pkg.sv - shared mode encoding and sizing helper for the LED blinker
package blinker_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    // Channel-select width; a single channel still needs a one-bit select port.
    function automatic int ch_sel_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/blink_channel.sv
// rtl/blink_channel.sv - one LED channel: mode/period/duty state, tick counter, phase and lit decode
module blink_channel
    import blinker_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_tick,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_duty,
    output logic             o_lit
);

    mode_t            r_mode;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_duty;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    logic [CNT_W-1:0] w_eff_period;
    logic             w_wrap;

    // A zero period is treated as one tick so the counter always has a legal wrap point.
    assign w_eff_period = (r_period == '0) ? CNT_W'(1) : r_period;
    assign w_wrap       = (r_cnt >= (w_eff_period - CNT_W'(1)));

    // A load wins over a coincident tick, so a freshly written channel always starts at cnt 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= MODE_OFF;
            r_period <= '0;
            r_duty   <= '0;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else if (i_load) begin
            r_mode   <= mode_t'(i_mode);
            r_period <= i_period;
            r_duty   <= i_duty;
            r_cnt    <= '0;
            r_phase  <= 1'b1;
        end else if (i_tick) begin
            if (w_wrap) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        o_lit = 1'b0;
        case (r_mode)
            MODE_OFF:   o_lit = 1'b0;
            MODE_ON:    o_lit = 1'b1;
            MODE_BLINK: o_lit = r_phase;
            MODE_PWM:   o_lit = (r_cnt < r_duty);
            default:    o_lit = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_channel_blinker.sv
// rtl/multi_channel_blinker.sv - prescaled timebase, config write decode and NUM_CH blink channels
module multi_channel_blinker
    import blinker_pkg::*;
#(
    parameter int CLK_HZ     = 12_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int NUM_CH     = 8,
    parameter int CNT_W      = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ch_sel_w(NUM_CH)-1:0] cfg_ch,
    input  logic [1:0]                  cfg_mode,
    input  logic [CNT_W-1:0]            cfg_period,
    input  logic [CNT_W-1:0]            cfg_duty,
    output logic [NUM_CH-1:0]           led_out,
    output logic                        tick_out
);

    localparam int   CH_W     = ch_sel_w(NUM_CH);
    localparam int   PRESCALE = CLK_HZ / TICK_HZ;
    localparam int   PRESC_W  = $clog2(PRESCALE);
    localparam logic POL      = (ACTIVE_LOW != 0);

    logic [PRESC_W-1:0] r_presc;
    logic               r_cfg_ready;
    logic [NUM_CH-1:0]  r_led;

    logic               w_tick;
    logic               w_accept;
    logic [NUM_CH-1:0]  w_load;
    logic [NUM_CH-1:0]  w_lit;

    assign w_tick = (r_presc == PRESC_W'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // Ready drops for exactly the cycle after each acceptance, pacing writes to one per two cycles.
    assign w_accept = cfg_valid & r_cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_ready <= 1'b1;
        end else begin
            r_cfg_ready <= ~w_accept;
        end
    end

    // Selects that match no channel are still accepted but load nothing.
    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign w_load[g] = w_accept & (cfg_ch == CH_W'(g));

            blink_channel #(
                .CNT_W (CNT_W)
            ) u_channel (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_load   (w_load[g]),
                .i_tick   (w_tick),
                .i_mode   (cfg_mode),
                .i_period (cfg_period),
                .i_duty   (cfg_duty),
                .o_lit    (w_lit[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= {NUM_CH{POL}};
        end else begin
            r_led <= w_lit ^ {NUM_CH{POL}};
        end
    end

    assign led_out   = r_led;
    assign tick_out  = w_tick;
    assign cfg_ready = r_cfg_ready;

endmodule
